udma_ext_per_rx_arbiter: RTL and testbench

Round-robin burst arbiter that shares the single uDMA RX channel of the external-peripheral subsystem between up to NB_SRC independent stream producers (traffic generators, sensor front-ends). It sits between the producers and the RX data port of the external-peripheral top, in the peripheral clock domain. Each grant is held for up to BURST_LEN beats, then ownership rotates. Output beats pass through a one-entry register stage.

---
 rtl/udma_ext_per_arb_pkg.sv | 16 +
 rtl/udma_ext_per_rr_picker.sv | 35 +++
 rtl/udma_ext_per_rx_arbiter.sv | 143 ++++++++++++++
 tb/tb_udma_ext_per_rx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_ext_per_arb_pkg.sv
// Shared types and constants for the external-peripheral RX arbiter.
// Contents: FSM state enum, uDMA datasize type, source-count ceiling and
// beat counter width.
package udma_ext_per_arb_pkg;

  localparam int unsigned NB_SRC_MAX = 8;
  localparam int unsigned BEAT_CNT_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  typedef logic [1:0] datasize_t;

endpackage

// File: rtl/udma_ext_per_rr_picker.sv
// Combinational round-robin first-one search.
// Ports:
//   i_req          per-source request vector
//   i_last_owner   most recently granted source; search starts just above it
//   o_grant_idx    selected source (0 when nothing requests)
//   o_grant_valid  at least one request is set
module udma_ext_per_rr_picker
  import udma_ext_per_arb_pkg::*;
#(
  parameter  int unsigned NB_SRC = 4,
  localparam int unsigned IDX_W  = $clog2(NB_SRC)
) (
  input  logic [NB_SRC-1:0] i_req,
  input  logic [IDX_W-1:0]  i_last_owner,
  output logic [IDX_W-1:0]  o_grant_idx,
  output logic              o_grant_valid
);

  logic [IDX_W-1:0] w_idx;

  // Walk last_owner+1 .. last_owner+NB_SRC (mod NB_SRC); last_owner is visited last.
  always_comb begin
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_idx         = '0;
    for (int unsigned k = 1; k <= NB_SRC; k++) begin
      w_idx = IDX_W'((32'(i_last_owner) + k) % NB_SRC);
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant_idx   = w_idx;
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udma_ext_per_rx_arbiter.sv
// Round-robin burst arbiter sharing the uDMA RX channel among NB_SRC producers.
// A grant is held for up to BURST_LEN beats, then ownership rotates; beats go
// out through a one-entry register stage.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   cfg_en_i, cfg_src_mask_i  arbiter enable, per-source grant enable
//   src_data_i/_datasize_i    flattened per-source beat payload
//   src_valid_i/src_ready_o   per-source handshake (ready is one-hot or zero)
//   data_rx_*                 registered beat towards uDMA RX
//   owner_o, busy_o           current/last owner, high while transferring
//   burst_done_o              pulse in the first IDLE cycle after a burst
module udma_ext_per_rx_arbiter
  import udma_ext_per_arb_pkg::*;
#(
  parameter  int unsigned NB_SRC     = 4,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned BURST_LEN  = 8,
  localparam int unsigned IDX_W      = $clog2(NB_SRC)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cfg_en_i,
  input  logic [NB_SRC-1:0]            cfg_src_mask_i,
  input  logic [NB_SRC*DATA_WIDTH-1:0] src_data_i,
  input  logic [NB_SRC*2-1:0]          src_datasize_i,
  input  logic [NB_SRC-1:0]            src_valid_i,
  output logic [NB_SRC-1:0]            src_ready_o,
  output logic [DATA_WIDTH-1:0]        data_rx_o,
  output logic [1:0]                   data_rx_datasize_o,
  output logic                         data_rx_valid_o,
  input  logic                         data_rx_ready_i,
  output logic [IDX_W-1:0]             owner_o,
  output logic                         busy_o,
  output logic                         burst_done_o
);

  arb_state_e              r_state;
  arb_state_e              w_state_nxt;
  logic [IDX_W-1:0]        r_owner;
  logic [IDX_W-1:0]        r_last_owner;
  logic [BEAT_CNT_W-1:0]   r_beat_cnt;
  logic [DATA_WIDTH-1:0]   r_data;
  datasize_t               r_dsize;
  logic                    r_valid;
  logic                    r_burst_done;

  logic [NB_SRC-1:0]       w_req;
  logic [IDX_W-1:0]        w_grant_idx;
  logic                    w_grant_valid;
  logic                    w_grant;
  logic                    w_owner_valid;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_last_beat;
  logic                    w_xfer_end;
  logic [DATA_WIDTH-1:0]   w_src_data  [NB_SRC];
  datasize_t               w_src_dsize [NB_SRC];

  // Unpack the flattened per-source payload buses.
  for (genvar g = 0; g < NB_SRC; g++) begin : g_unpack
    assign w_src_data[g]  = src_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_src_dsize[g] = src_datasize_i[g*2 +: 2];
  end

  assign w_req = src_valid_i & cfg_src_mask_i;

  udma_ext_per_rr_picker #(
    .NB_SRC (NB_SRC)
  ) u_picker (
    .i_req         (w_req),
    .i_last_owner  (r_last_owner),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  // Ready depends only on state/owner/enable and the output stage, never on src_valid_i.
  assign w_grant       = cfg_en_i & w_grant_valid;
  assign w_owner_valid = src_valid_i[r_owner];
  assign w_ready       = (r_state == ST_XFER) & cfg_en_i & (~r_valid | data_rx_ready_i);
  assign w_accept      = w_ready & w_owner_valid;
  assign w_last_beat   = (r_beat_cnt == BEAT_CNT_W'(BURST_LEN - 1));
  // Mask bits are ignored here: a burst in flight ends only on length, gap or disable.
  assign w_xfer_end    = (w_accept & w_last_beat) | ~w_owner_valid | ~cfg_en_i;

  assign src_ready_o        = w_ready ? (NB_SRC'(1) << r_owner) : '0;
  assign data_rx_o          = r_data;
  assign data_rx_datasize_o = r_dsize;
  assign data_rx_valid_o    = r_valid;
  assign owner_o            = r_owner;
  assign busy_o             = (r_state == ST_XFER);
  assign burst_done_o       = r_burst_done;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant)    w_state_nxt = ST_XFER;
      ST_XFER: if (w_xfer_end) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // Ownership and beat counting; last_owner resets to the top so source 0 wins first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_owner      <= '0;
      r_last_owner <= IDX_W'(NB_SRC - 1);
      r_beat_cnt   <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_burst_done <= (r_state == ST_XFER) & w_xfer_end;
      if ((r_state == ST_IDLE) && w_grant) begin
        r_owner      <= w_grant_idx;
        r_last_owner <= w_grant_idx;
        r_beat_cnt   <= '0;
      end else if (w_accept) begin
        r_beat_cnt   <= r_beat_cnt + BEAT_CNT_W'(1);
      end
    end
  end

  // One-entry output stage; payload holds while stalled, reload on drain+accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_dsize <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_data  <= w_src_data[r_owner];
      r_dsize <= w_src_dsize[r_owner];
      r_valid <= 1'b1;
    end else if (data_rx_ready_i) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_udma_ext_per_rx_arbiter.sv
// Randomised scoreboard bench for udma_ext_per_rx_arbiter: producers are bench
// models, a reference arbiter model predicts every output, accepted beats are
// queued and popped when the DUT hands them to the RX side.
module tb_udma_ext_per_rx_arbiter;

  localparam int unsigned NB_SRC = 4;
  localparam int unsigned DW     = 32;
  localparam int unsigned BL     = 8;
  localparam int unsigned IW     = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cfg_en;
  logic [NB_SRC-1:0]      cfg_mask;
  logic [NB_SRC*DW-1:0]   src_data;
  logic [NB_SRC*2-1:0]    src_ds;
  logic [NB_SRC-1:0]      src_valid;
  logic [NB_SRC-1:0]      src_ready;
  logic [DW-1:0]          rx_data;
  logic [1:0]             rx_ds;
  logic                   rx_valid;
  logic                   rx_ready;
  logic [IW-1:0]          owner;
  logic                   busy;
  logic                   bdone;

  udma_ext_per_rx_arbiter #(
    .NB_SRC     (NB_SRC),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .cfg_en_i           (cfg_en),
    .cfg_src_mask_i     (cfg_mask),
    .src_data_i         (src_data),
    .src_datasize_i     (src_ds),
    .src_valid_i        (src_valid),
    .src_ready_o        (src_ready),
    .data_rx_o          (rx_data),
    .data_rx_datasize_o (rx_ds),
    .data_rx_valid_o    (rx_valid),
    .data_rx_ready_i    (rx_ready),
    .owner_o            (owner),
    .busy_o             (busy),
    .burst_done_o       (bdone)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Stimulus knobs (main) and per-source accepted-beat counters (monitor).
  int acc_cnt [NB_SRC] = '{default: 0};
  int budget  [NB_SRC] = '{default: 0};
  int vpct    = 100;
  int rdy_mode = 0;

  logic [33:0] sb_q [$];
  int log_own [$];
  int log_len [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin choice: first requester strictly after 'last', wrapping.
  function automatic int rr_pick(input logic [NB_SRC-1:0] req, input int last);
    for (int k = 1; k <= NB_SRC; k++) begin
      int idx = (last + k) % NB_SRC;
      if (req[IW'(idx)]) return idx;
    end
    return -1;
  endfunction

  // Producer / RX-ready driver.
  initial begin
    logic [3:0] pat;
    int         pat_idx;
    pat       = 4'b1001;
    pat_idx   = 0;
    src_valid = '0;
    src_data  = '0;
    src_ds    = '0;
    rx_ready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NB_SRC; i++) begin
        src_valid[i]          = (acc_cnt[i] < budget[i]) && (int'($urandom_range(99)) < vpct);
        src_data[i*DW +: DW]  = {8'(i), 24'(acc_cnt[i])};
        src_ds[i*2 +: 2]      = 2'(acc_cnt[i] + i);
      end
      case (rdy_mode)
        0:       rx_ready = 1'b1;
        1:       begin rx_ready = pat[pat_idx[1:0]]; pat_idx++; end
        2:       rx_ready = ($urandom_range(99) < 60);
        default: rx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: reference model, scoreboard and burst logger.
  initial begin
    int          m_busy, m_owner, m_last, m_cnt, m_vld, m_done;
    logic [DW-1:0] m_data;
    logic [1:0]  m_ds;
    int          prev_busy, cur_own, cur_len;
    logic [NB_SRC-1:0] req, exp_rdy;
    logic [33:0] exp_beat;
    int          acc, ending;
    m_busy = 0; m_owner = 0; m_last = NB_SRC - 1; m_cnt = 0; m_vld = 0; m_done = 0;
    m_data = '0; m_ds = '0; prev_busy = 0; cur_own = 0; cur_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 0; m_owner = 0; m_last = NB_SRC - 1; m_cnt = 0; m_vld = 0; m_done = 0;
        m_data = '0; m_ds = '0; prev_busy = 0;
        sb_q.delete();
        continue;
      end
      exp_rdy = (m_busy != 0 && cfg_en && (m_vld == 0 || rx_ready)) ? NB_SRC'(1) << m_owner : '0;
      chk("busy", busy, m_busy);
      chk("owner", owner, m_owner);
      chk("burst_done", bdone, m_done);
      chk("rx_valid", rx_valid, m_vld);
      chk("rx_data", rx_data, m_data);
      chk("rx_datasize", rx_ds, m_ds);
      chk("src_ready", src_ready, exp_rdy);

      if (rx_valid && rx_ready) begin
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          exp_beat = sb_q.pop_front();
          chk("sb_beat", {rx_ds, rx_data}, exp_beat);
        end
      end

      if (busy && prev_busy == 0) begin cur_own = owner; cur_len = 0; end
      for (int i = 0; i < NB_SRC; i++)
        if (src_valid[i] && src_ready[i]) begin acc_cnt[i]++; if (busy) cur_len++; end
      if (bdone) begin log_own.push_back(cur_own); log_len.push_back(cur_len); end
      prev_busy = busy;

      // Model advance over the coming edge.
      req = src_valid & cfg_mask;
      if (m_busy == 0) begin
        m_done = 0;
        if (rx_ready) m_vld = 0;
        if (cfg_en && req != 0) begin
          m_owner = rr_pick(req, m_last); m_last = m_owner; m_cnt = 0; m_busy = 1;
        end
      end else begin
        acc = (cfg_en && (m_vld == 0 || rx_ready) && src_valid[IW'(m_owner)]) ? 1 : 0;
        if (acc != 0) begin
          m_data = src_data[m_owner*DW +: DW];
          m_ds   = src_ds[m_owner*2 +: 2];
          m_vld  = 1;
          m_cnt++;
          sb_q.push_back({m_ds, m_data});
        end else if (rx_ready) m_vld = 0;
        ending = ((acc != 0 && m_cnt == BL) || !src_valid[IW'(m_owner)] || !cfg_en) ? 1 : 0;
        m_done = ending;
        if (ending != 0) m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic stop_all();
    for (int i = 0; i < NB_SRC; i++) budget[i] = acc_cnt[i];
    repeat (6) tick();
  endtask

  task automatic start_all(input int n);
    for (int i = 0; i < NB_SRC; i++) budget[i] = acc_cnt[i] + n;
  endtask

  task automatic reset_dut();
    stop_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_bursts(input int target, input int max_cyc, input string name);
    int n = 0;
    while (log_own.size() < target && n < max_cyc) begin tick(); n++; end
    chk(name, 64'(log_own.size() >= target), 1);
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 100) begin tick(); n++; end
    chk(name, busy, 1);
  endtask

  initial begin
    int base;
    int exp_own [5];
    rst = 1'b1; cfg_en = 1'b0; cfg_mask = '1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_ready", src_ready, 0);
    tick();
    cfg_en = 1'b1;

    // Single source, 20 beats: 8 + 8 + 4.
    base = log_own.size();
    budget[0] = acc_cnt[0] + 20;
    wait_bursts(base + 3, 300, "single_bursts");
    chk("single_len0", log_len[base], 8);
    chk("single_len1", log_len[base+1], 8);
    chk("single_len2", log_len[base+2], 4);
    chk("single_own2", log_own[base+2], 0);
    repeat (4) tick();
    chk("single_drain", sb_q.size(), 0);

    // Fairness with everyone requesting.
    reset_dut();
    base = log_own.size();
    start_all(1000);
    wait_bursts(base + 5, 400, "fair_bursts");
    exp_own = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      chk("fair_owner", log_own[base+k], exp_own[k]);
      chk("fair_len", log_len[base+k], 8);
    end

    // Backpressure pattern 1,0,0,1 on a 12-beat stream.
    reset_dut();
    rdy_mode = 1;
    base = log_own.size();
    budget[1] = acc_cnt[1] + 12;
    wait_bursts(base + 2, 400, "bp_bursts");
    chk("bp_len0", log_len[base], 8);
    chk("bp_len1", log_len[base+1], 4);
    chk("bp_own", log_own[base+1], 1);
    rdy_mode = 0;
    repeat (4) tick();
    chk("bp_drain", sb_q.size(), 0);

    // Gap release: src2 stops after 3 beats, src3 waiting.
    reset_dut();
    base = log_own.size();
    budget[2] = acc_cnt[2] + 3;
    budget[3] = acc_cnt[3] + 10;
    wait_bursts(base + 2, 200, "gap_bursts");
    chk("gap_own0", log_own[base], 2);
    chk("gap_len0", log_len[base], 3);
    chk("gap_own1", log_own[base+1], 3);
    chk("gap_len1", log_len[base+1], 8);

    // Mask 1010: only sources 1 and 3 alternate.
    reset_dut();
    cfg_mask = 4'b1010;
    base = log_own.size();
    start_all(1000);
    wait_bursts(base + 3, 300, "mask_bursts");
    chk("mask_own0", log_own[base], 1);
    chk("mask_own1", log_own[base+1], 3);
    chk("mask_own2", log_own[base+2], 1);
    stop_all();
    cfg_mask = '1;

    // Enable drop mid-burst.
    reset_dut();
    start_all(1000);
    wait_busy("en_busy");
    repeat (2) tick();
    cfg_en = 1'b0;
    @(negedge clk);
    chk("en_ready_now", src_ready, 0);
    chk("en_still_busy", busy, 1);
    @(negedge clk);
    chk("en_idle", busy, 0);
    chk("en_done", bdone, 1);
    tick();
    cfg_en = 1'b1;
    stop_all();

    // Random traffic.
    reset_dut();
    vpct = 70; rdy_mode = 2;
    start_all(100000);
    repeat (1500) begin
      tick();
      cfg_en = ($urandom_range(99) < 92);
      if ($urandom_range(99) < 5) cfg_mask = 4'($urandom_range(15));
    end
    cfg_en = 1'b1; cfg_mask = '1; vpct = 100; rdy_mode = 0;
    stop_all();
    chk("rand_drain", sb_q.size(), 0);

    // Async reset with the output stage full and stalled.
    start_all(1000);
    rdy_mode = 3;
    wait_busy("ar_busy");
    repeat (3) tick();
    @(negedge clk); #2;
    chk("ar_full", rx_valid, 1);
    rst = 1'b1;
    #1;
    chk("ar_valid", rx_valid, 0);
    chk("ar_data", rx_data, 0);
    chk("ar_ds", rx_ds, 0);
    chk("ar_ready", src_ready, 0);
    chk("ar_busy0", busy, 0);
    chk("ar_owner", owner, 0);
    chk("ar_done", bdone, 0);
    @(negedge clk);
    rdy_mode = 0;
    tick();
    rst = 1'b0;
    base = log_own.size();
    wait_bursts(base + 1, 200, "ar_bursts");
    chk("ar_first_owner", log_own[base], 0);
    stop_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
